// File: rtl/vc_tgen_pkg.sv
// rtl/vc_tgen_pkg.sv - shared types and flit packing helper for the VC traffic generator
// Purpose: flit type / payload mode / FSM state enums and the function that
//          assembles {type, dest, payload} into a flit word.
// Ports:   none (package)
package vc_tgen_pkg;

  typedef enum logic [1:0] {
    HT   = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10,
    TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_INC   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Wide scratch bus so one helper serves any FLIT_WIDTH up to MAX_FW;
  // callers truncate the result to their own flit width.
  localparam int unsigned MAX_FW = 256;
  typedef logic [MAX_FW-1:0] flit_bus_t;

  // dest and payload must already be confined to their field widths.
  function automatic flit_bus_t pack_flit(input flit_type_e  ftype,
                                          input flit_bus_t   dest,
                                          input flit_bus_t   payload,
                                          input int unsigned dest_bits,
                                          input int unsigned flit_width);
    flit_bus_t f;
    f = payload;
    f = f | (dest << (flit_width - 2 - dest_bits));
    f = f | (flit_bus_t'(ftype) << (flit_width - 2));
    return f;
  endfunction

endpackage

// File: rtl/tgen_lfsr.sv
// rtl/tgen_lfsr.sv - right-shifting Galois LFSR with advance enable
// Purpose: pseudo-random payload source; steps once per cycle with adv_i high.
// Ports:   clk_i   - clock
//          reset_i - synchronous active-high reset, loads SEED
//          adv_i   - advance one step this cycle
//          value_o - current LFSR state
module tgen_lfsr #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hACE1_2025),
  // x^32 + x^22 + x^2 + x + 1 in right-shift Galois form
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h8020_0003)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             adv_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/vc_traffic_gen.sv
// rtl/vc_traffic_gen.sv - credit-paced head/body/tail flit injector for one router input port
// Purpose: on start, latches a burst description and emits num_pkts packets of
//          pkt_len flits, separated by gap idle cycles, one flit per cycle while
//          credits remain.
// Ports:   clk, reset            - clock, synchronous active-high reset
//          start, cfg_*          - burst launch pulse and burst configuration
//          credit_inc            - credit return pulse from the router
//          flit_out, flit_valid  - registered flit stream to the router
//          busy, done, pkts_sent - burst status
//          credit_cnt, credit_err- credit state, sticky over-return flag
module vc_traffic_gen
  import vc_tgen_pkg::*;
#(
  parameter int          FLIT_WIDTH  = 32,
  parameter int          DEST_BITS   = 3,
  parameter int          CREDITS     = 4,
  parameter int          MAX_PKT_LEN = 8,
  parameter int          CNT_WIDTH   = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2025
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [1:0]                         cfg_mode,
  input  logic [DEST_BITS-1:0]               cfg_dest,
  input  logic [CNT_WIDTH-1:0]               cfg_num_pkts,
  input  logic [$clog2(MAX_PKT_LEN+1)-1:0]   cfg_pkt_len,
  input  logic [7:0]                         cfg_gap,
  input  logic [FLIT_WIDTH-3-DEST_BITS:0]    cfg_fixed,
  input  logic                               credit_inc,
  output logic [FLIT_WIDTH-1:0]              flit_out,
  output logic                               flit_valid,
  output logic                               busy,
  output logic                               done,
  output logic [CNT_WIDTH-1:0]               pkts_sent,
  output logic [$clog2(CREDITS+1)-1:0]       credit_cnt,
  output logic                               credit_err
);

  localparam int PW = FLIT_WIDTH - 2 - DEST_BITS;
  localparam int LW = $clog2(MAX_PKT_LEN + 1);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [LW-1:0] MAX_LEN      = LW'(MAX_PKT_LEN);
  localparam logic [CW-1:0] FULL_CREDITS = CW'(CREDITS);

  state_e                state_q, state_d;
  mode_e                 mode_q;
  logic [DEST_BITS-1:0]  dest_q;
  logic [CNT_WIDTH-1:0]  num_q, pkts_q, inc_cnt_q;
  logic [LW-1:0]         len_q, idx_q;
  logic [7:0]            gap_q, gap_cnt_q;
  logic [PW-1:0]         fixed_q, payload;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  err_q, valid_q;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic [31:0]           lfsr_val;
  logic                  accept, send, is_tail, last_pkt;
  flit_type_e            ftype;

  assign accept   = (state_q == IDLE) && start;
  assign send     = (state_q == SEND) && (credit_q != '0);
  assign is_tail  = (idx_q == len_q - LW'(1));
  assign last_pkt = ((pkts_q + CNT_WIDTH'(1)) == num_q);

  tgen_lfsr #(
    .WIDTH (32),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .reset_i (reset),
    .adv_i   (send),
    .value_o (lfsr_val)
  );

  always_comb begin
    if (len_q == LW'(1))    ftype = HT;
    else if (idx_q == '0)   ftype = HEAD;
    else if (is_tail)       ftype = TAIL;
    else                    ftype = BODY;
  end

  always_comb begin
    case (mode_q)
      MODE_LFSR: payload = PW'(lfsr_val);
      MODE_INC:  payload = PW'(inc_cnt_q);
      default:   payload = fixed_q;
    endcase
  end

  always_comb begin
    flit_d = '0;
    if (send) begin
      flit_d = FLIT_WIDTH'(pack_flit(ftype, flit_bus_t'(dest_q), flit_bus_t'(payload),
                                     DEST_BITS, FLIT_WIDTH));
    end
  end

  // A send and a return in the same cycle cancel out; returns saturate.
  always_comb begin
    credit_d = credit_q;
    if (send && !credit_inc)                           credit_d = credit_q - CW'(1);
    else if (!send && credit_inc && credit_q != FULL_CREDITS) credit_d = credit_q + CW'(1);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (cfg_num_pkts == '0) ? DONE : SEND;
      SEND: if (send && is_tail) begin
              if (last_pkt)            state_d = DONE;
              else if (gap_q != '0)    state_d = GAP;
              else                     state_d = SEND;
            end
      GAP:  if (gap_cnt_q == 8'd1) state_d = SEND;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == SEND) || (state_q == GAP);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_FIXED;
      dest_q    <= '0;
      num_q     <= '0;
      len_q     <= MAX_LEN;
      gap_q     <= '0;
      fixed_q   <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      pkts_q    <= '0;
      inc_cnt_q <= '0;
      credit_q  <= FULL_CREDITS;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      flit_q    <= '0;
    end else begin
      credit_q <= credit_d;
      if (credit_inc && credit_q == FULL_CREDITS) err_q <= 1'b1;
      valid_q  <= send;
      flit_q   <= flit_d;
      if (accept) begin
        mode_q    <= mode_e'(cfg_mode);
        dest_q    <= cfg_dest;
        num_q     <= cfg_num_pkts;
        len_q     <= (cfg_pkt_len == '0 || cfg_pkt_len > MAX_LEN) ? MAX_LEN : cfg_pkt_len;
        gap_q     <= cfg_gap;
        fixed_q   <= cfg_fixed;
        idx_q     <= '0;
        pkts_q    <= '0;
        inc_cnt_q <= '0;
      end
      if (send) begin
        inc_cnt_q <= inc_cnt_q + CNT_WIDTH'(1);
        if (is_tail) begin
          idx_q     <= '0;
          pkts_q    <= pkts_q + CNT_WIDTH'(1);
          gap_cnt_q <= gap_q;
        end else begin
          idx_q <= idx_q + LW'(1);
        end
      end
      if (state_q == GAP) gap_cnt_q <= gap_cnt_q - 8'd1;
    end
  end

  assign flit_out   = flit_q;
  assign flit_valid = valid_q;
  assign pkts_sent  = pkts_q;
  assign credit_cnt = credit_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_vc_traffic_gen.sv
// tb/tb_vc_traffic_gen.sv - self-checking bench for vc_traffic_gen with a burst-level reference model
module tb_vc_traffic_gen;

  localparam int          CR   = 4;
  localparam int          ML   = 8;
  localparam logic [31:0] SEED = 32'hACE1_2025;

  logic        clk = 1'b0;
  logic        reset, start, credit_inc;
  logic [1:0]  cfg_mode;
  logic [2:0]  cfg_dest;
  logic [15:0] cfg_num_pkts;
  logic [3:0]  cfg_pkt_len;
  logic [7:0]  cfg_gap;
  logic [26:0] cfg_fixed;
  logic [31:0] flit_out;
  logic        flit_valid, busy, done, credit_err;
  logic [15:0] pkts_sent;
  logic [2:0]  credit_cnt;

  vc_traffic_gen dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_mode     (cfg_mode),
    .cfg_dest     (cfg_dest),
    .cfg_num_pkts (cfg_num_pkts),
    .cfg_pkt_len  (cfg_pkt_len),
    .cfg_gap      (cfg_gap),
    .cfg_fixed    (cfg_fixed),
    .credit_inc   (credit_inc),
    .flit_out     (flit_out),
    .flit_valid   (flit_valid),
    .busy         (busy),
    .done         (done),
    .pkts_sent    (pkts_sent),
    .credit_cnt   (credit_cnt),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  // Model: a burst is a queue of slots (flit or idle gap cycle) consumed in order.
  typedef struct packed {
    logic       is_gap;
    logic [1:0] ftype;
  } slot_t;

  slot_t       mq[$];
  int          m_credits, m_pkts;
  bit          m_err, m_done, exp_valid;
  logic [31:0] m_lfsr, exp_flit;
  logic [15:0] m_inc;
  logic [1:0]  m_mode;
  logic [2:0]  m_dest;
  logic [26:0] m_fixed;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          obs_flits, obs_done, obs_done_valid;
  int          obs_cyc[$];
  logic [26:0] obs_pl[$];
  logic [26:0] run_a[$];
  logic [26:0] run_b[$];
  logic [31:0] last_flit;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit inc);
    bit          sent, new_done;
    slot_t       s;
    int          len;
    logic [26:0] pl;
    sent = 0; new_done = 0; exp_valid = 0; exp_flit = '0;
    if (rst) begin
      mq.delete(); m_credits = CR; m_err = 0; m_lfsr = SEED;
      m_inc = '0; m_pkts = 0; m_done = 0;
      return;
    end
    if (st && mq.size() == 0 && !m_done) begin
      m_mode = cfg_mode; m_dest = cfg_dest; m_fixed = cfg_fixed;
      m_pkts = 0; m_inc = '0;
      len = (cfg_pkt_len == 0 || int'(cfg_pkt_len) > ML) ? ML : int'(cfg_pkt_len);
      if (cfg_num_pkts == 0) new_done = 1;
      for (int p = 0; p < int'(cfg_num_pkts); p++) begin
        for (int i = 0; i < len; i++) begin
          s.is_gap = 1'b0;
          s.ftype  = (len == 1) ? 2'b00 : (i == 0) ? 2'b01 : (i == len - 1) ? 2'b11 : 2'b10;
          mq.push_back(s);
        end
        if (p < int'(cfg_num_pkts) - 1) begin
          for (int g = 0; g < int'(cfg_gap); g++) begin
            s.is_gap = 1'b1; s.ftype = 2'b00;
            mq.push_back(s);
          end
        end
      end
    end else if (mq.size() > 0) begin
      if (mq[0].is_gap) begin
        s = mq.pop_front();
      end else if (m_credits > 0) begin
        s = mq.pop_front();
        sent = 1;
        case (m_mode)
          2'd1:    pl = m_lfsr[26:0];
          2'd2:    pl = 27'(m_inc);
          default: pl = m_fixed;
        endcase
        exp_flit  = {s.ftype, m_dest, pl};
        exp_valid = 1;
        m_lfsr    = lfsr_next(m_lfsr);
        m_inc     = m_inc + 16'd1;
        if (s.ftype == 2'b00 || s.ftype == 2'b11) m_pkts++;
        if (mq.size() == 0) new_done = 1;
      end
    end
    if (inc && m_credits == CR) m_err = 1;
    if (sent && !inc) m_credits--;
    else if (inc && !sent && m_credits < CR) m_credits++;
    m_done = new_done;
  endtask

  task automatic compare_all();
    chk("flit_valid", 64'(flit_valid), 64'(exp_valid));
    if (exp_valid) chk("flit_out", 64'(flit_out), 64'(exp_flit));
    chk("busy", 64'(busy), 64'(mq.size() > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("pkts_sent", 64'(pkts_sent), 64'(m_pkts));
    chk("credit_cnt", 64'(credit_cnt), 64'(m_credits));
    chk("credit_err", 64'(credit_err), 64'(m_err));
    if (flit_valid === 1'b1) begin
      obs_flits++;
      obs_cyc.push_back(cyc);
      obs_pl.push_back(flit_out[26:0]);
      last_flit = flit_out;
    end
    if (done === 1'b1) begin
      obs_done++;
      if (flit_valid === 1'b1) obs_done_valid++;
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit inc);
    reset = rst; start = st; credit_inc = inc;
    model_edge(rst, st, inc);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    start = 1'b0; credit_inc = 1'b0;
    compare_all();
  endtask

  task automatic clear_obs();
    obs_flits = 0; obs_done = 0; obs_done_valid = 0;
    obs_cyc.delete(); obs_pl.delete(); last_flit = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; credit_inc = 1'b0;
    cfg_mode = '0; cfg_dest = '0; cfg_num_pkts = '0; cfg_pkt_len = '0;
    cfg_gap = '0; cfg_fixed = '0;
    clear_obs();
    @(negedge clk);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst_credit_cnt", 64'(credit_cnt), 64'd4);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_flit_out", 64'(flit_out), 64'd0);
    chk("rst_pkts_sent", 64'(pkts_sent), 64'd0);

    // single head-tail flit, incrementing payload
    cfg_mode = 2'd2; cfg_dest = 3'd3; cfg_num_pkts = 16'd1; cfg_pkt_len = 4'd1;
    cfg_gap = 8'd0; cfg_fixed = 27'h5A5_A5A5;
    clear_obs();
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);
    chk("t1_nflits", 64'(obs_flits), 64'd1);
    chk("t1_flit", 64'(last_flit), 64'h1800_0000);
    chk("t1_done_with_flit", 64'(obs_done_valid), 64'd1);
    chk("t1_credit", 64'(credit_cnt), 64'd3);

    // two 3-flit packets, gap 2, credit return every cycle
    cfg_num_pkts = 16'd2; cfg_pkt_len = 4'd3; cfg_gap = 8'd2;
    clear_obs();
    step(0, 1, 1);
    repeat (14) step(0, 0, 1);
    chk("t2_nflits", 64'(obs_flits), 64'd6);
    if (obs_pl.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t2_payload", 64'(obs_pl[i]), 64'(i));
      chk("t2_gap_spacing", 64'(obs_cyc[3] - obs_cyc[2]), 64'd3);
    end
    chk("t2_last_type", 64'(last_flit[31:30]), 64'd3);
    chk("t2_pkts_sent", 64'(pkts_sent), 64'd2);
    chk("t2_credit", 64'(credit_cnt), 64'd4);
    chk("t2_credit_err", 64'(credit_err), 64'd1);

    // credit starvation on an 8-flit packet
    step(1, 0, 0);
    cfg_mode = 2'd0; cfg_dest = 3'd1; cfg_num_pkts = 16'd1; cfg_pkt_len = 4'd8; cfg_gap = 8'd0;
    clear_obs();
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    chk("t3_stall_nflits", 64'(obs_flits), 64'd4);
    chk("t3_stall_credit", 64'(credit_cnt), 64'd0);
    chk("t3_stall_valid", 64'(flit_valid), 64'd0);
    chk("t3_stall_busy", 64'(busy), 64'd1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    repeat (6) step(0, 0, 0);
    chk("t3_two_more", 64'(obs_flits), 64'd6);
    k = 0;
    while (busy && k < 40) begin
      step(0, 0, 1);
      k++;
    end
    chk("t3_finish_in_time", 64'(k < 40), 64'd1);
    chk("t3_total", 64'(obs_flits), 64'd8);

    // over-return of credits
    step(1, 0, 0);
    step(0, 0, 1);
    chk("t4_credit_sat", 64'(credit_cnt), 64'd4);
    chk("t4_err_set", 64'(credit_err), 64'd1);
    repeat (3) step(0, 0, 0);
    chk("t4_err_sticky", 64'(credit_err), 64'd1);
    step(1, 0, 0);
    chk("t4_err_cleared", 64'(credit_err), 64'd0);

    // LFSR payload repeatability across resets, mid-burst start ignored
    for (int r = 0; r < 2; r++) begin
      step(1, 0, 0);
      cfg_mode = 2'd1; cfg_dest = 3'd5; cfg_num_pkts = 16'd2; cfg_pkt_len = 4'd3; cfg_gap = 8'd1;
      clear_obs();
      step(0, 1, 1);
      repeat (3) step(0, 0, 1);
      cfg_mode = 2'd0; cfg_num_pkts = 16'd3; cfg_pkt_len = 4'd1;
      step(0, 1, 1);
      repeat (10) step(0, 0, 1);
      if (r == 0) run_a = obs_pl;
      else        run_b = obs_pl;
    end
    chk("t5_len_a", 64'(run_a.size()), 64'd6);
    chk("t5_len_b", 64'(run_b.size()), 64'd6);
    if (run_a.size() == 6 && run_b.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t5_repeat", 64'(run_b[i]), 64'(run_a[i]));
      chk("t5_lfsr0", 64'(run_a[0]), 64'h4E1_2025);
      chk("t5_lfsr1", 64'(run_a[1]), 64'h650_9011);
    end

    // reset in the middle of a packet, then an empty burst
    step(1, 0, 0);
    cfg_mode = 2'd2; cfg_dest = 3'd2; cfg_num_pkts = 16'd1; cfg_pkt_len = 4'd5; cfg_gap = 8'd0;
    clear_obs();
    step(0, 1, 0);
    k = 0;
    while (obs_flits < 3 && k < 10) begin
      step(0, 0, 0);
      k++;
    end
    chk("t6_third_flit", 64'(obs_flits), 64'd3);
    step(1, 0, 0);
    chk("t6_valid", 64'(flit_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_credit", 64'(credit_cnt), 64'd4);
    chk("t6_no_done", 64'(obs_done), 64'd0);
    cfg_num_pkts = 16'd0;
    clear_obs();
    step(0, 1, 0);
    chk("t6_empty_done", 64'(done), 64'd1);
    chk("t6_empty_busy", 64'(busy), 64'd0);
    step(0, 0, 0);
    chk("t6_done_pulse", 64'(done), 64'd0);
    chk("t6_empty_flits", 64'(obs_flits), 64'd0);

    // randomized bursts, credit returns, stray starts and rare resets
    step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit st, inc, rs;
      st = ($urandom_range(0, 7) == 0);
      if (st) begin
        cfg_mode     = 2'($urandom_range(0, 3));
        cfg_dest     = 3'($urandom_range(0, 7));
        cfg_num_pkts = 16'($urandom_range(0, 3));
        cfg_pkt_len  = 4'($urandom_range(0, 15));
        cfg_gap      = 8'($urandom_range(0, 3));
        cfg_fixed    = 27'($urandom);
      end
      inc = ($urandom_range(0, 9) < 4);
      rs  = ($urandom_range(0, 499) == 0);
      step(rs, st, inc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
